// File: rtl/msdap_main_ctrl_if.sv
// Bus between the MSDAP main sequencer and its surroundings.
//   master : deserialiser/datapath side (drives Start, clear_req, word strobes, comp_done)
//   slave  : msdap_main_ctrl (drives InReady, memory write strobes/address, x_ptr,
//            comp_start, sleep, overrun, state)
interface msdap_main_ctrl_if #(
   parameter int ADDR_X = 8
);
   logic              Start;
   logic              clear_req;
   logic              word_valid;
   logic              word_zero;
   logic              comp_done;
   logic              InReady;
   logic              rj_we;
   logic              coef_we;
   logic              data_we;
   logic [8:0]        wr_addr;
   logic              data_wr_zero;
   logic [ADDR_X-1:0] x_ptr;
   logic              comp_start;
   logic              sleep;
   logic              overrun;
   logic [2:0]        state;

   modport master (
      output Start, clear_req, word_valid, word_zero, comp_done,
      input  InReady, rj_we, coef_we, data_we, wr_addr, data_wr_zero,
             x_ptr, comp_start, sleep, overrun, state
   );

   modport slave (
      input  Start, clear_req, word_valid, word_zero, comp_done,
      output InReady, rj_we, coef_we, data_we, wr_addr, data_wr_zero,
             x_ptr, comp_start, sleep, overrun, state
   );
endinterface

// File: rtl/msdap_main_ctrl.sv
// Main sequencing FSM of the MSDAP core (Sclk domain).
// Steers incoming L/R word pairs into rj, coefficient or data memory, drives InReady,
// launches one datapath computation per stored sample, clears history on request and
// sleeps after a long run of all-zero input.
// Ports: Sclk, Reset_n (async, active low), bus (msdap_main_ctrl_if.slave).
//
//   state      | meaning
//   INIT       | zero all data memory, counters restart
//   READ_RJ    | load RJ_NUM rj words
//   READ_COEF  | load COEF_NUM coefficient words
//   WAIT_IN    | configured, waiting for first sample
//   WORKING    | storing samples and launching computations
//   CLEARING   | zero data memory, keep rj/coef, wait for clear_req release
//   SLEEPING   | silence detected, zero words ignored, output forced to 0
module msdap_main_ctrl #(
   parameter int RJ_NUM     = 16,
   parameter int COEF_NUM   = 512,
   parameter int DATA_DEPTH = 256,
   parameter int SLEEP_CNT  = 800
) (
   input logic Sclk,
   input logic Reset_n,
   msdap_main_ctrl_if.slave bus
);
   localparam int ADDR_X = $clog2(DATA_DEPTH);
   localparam int CNT_W  = $clog2(((COEF_NUM > DATA_DEPTH) ? COEF_NUM : DATA_DEPTH) + 1);
   localparam int ZC_W   = $clog2(SLEEP_CNT + 1);

   typedef enum logic [2:0] {
      S_INIT      = 3'd0,
      S_READ_RJ   = 3'd1,
      S_READ_COEF = 3'd2,
      S_WAIT_IN   = 3'd3,
      S_WORKING   = 3'd4,
      S_CLEARING  = 3'd5,
      S_SLEEPING  = 3'd6
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_X-1:0] x_ptr_q, x_ptr_d, x_ptr_inc;
   logic [ZC_W-1:0]   zero_q, zero_d;
   logic              busy_q, busy_d;
   logic              overrun_q, overrun_d;
   logic              comp_start_q, comp_start_d;
   logic              in_ready_q, in_ready_d;
   logic              take_data;
   logic              rj_we, coef_we, data_we, data_wr_zero;
   logic [8:0]        wr_addr;

   assign x_ptr_inc = x_ptr_q + ADDR_X'(1);

   always_ff @(posedge Sclk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= S_INIT;
         cnt_q        <= '0;
         x_ptr_q      <= '0;
         zero_q       <= '0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         comp_start_q <= 1'b0;
         in_ready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         x_ptr_q      <= x_ptr_d;
         zero_q       <= zero_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
         comp_start_q <= comp_start_d;
         in_ready_q   <= in_ready_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      x_ptr_d      = x_ptr_q;
      zero_d       = zero_q;
      // a launch in flight outranks a completion in the same cycle
      busy_d       = comp_start_q ? 1'b1 : (bus.comp_done ? 1'b0 : busy_q);
      overrun_d    = overrun_q;
      comp_start_d = 1'b0;
      if (bus.Start) begin
         state_d   = S_INIT;
         cnt_d     = '0;
         x_ptr_d   = '0;
         zero_d    = '0;
         busy_d    = 1'b0;
         overrun_d = 1'b0;
      end else begin
         case (state_q)
            S_INIT: begin
               if (cnt_q == CNT_W'(DATA_DEPTH - 1)) begin
                  state_d = S_READ_RJ;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_READ_RJ: begin
               if (bus.word_valid) begin
                  if (cnt_q == CNT_W'(RJ_NUM - 1)) begin
                     state_d = S_READ_COEF;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            S_READ_COEF: begin
               if (bus.word_valid) begin
                  if (cnt_q == CNT_W'(COEF_NUM - 1)) begin
                     state_d = S_WAIT_IN;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            S_WAIT_IN, S_WORKING, S_SLEEPING: begin
               if (bus.clear_req) begin
                  state_d = S_CLEARING;
                  cnt_d   = '0;
               end else if (take_data) begin
                  x_ptr_d = x_ptr_inc;
                  if (busy_q || comp_start_q) overrun_d = 1'b1;
                  else                        comp_start_d = 1'b1;
                  if (bus.word_zero) begin
                     zero_d  = (zero_q == ZC_W'(SLEEP_CNT)) ? zero_q : zero_q + ZC_W'(1);
                     state_d = (zero_d == ZC_W'(SLEEP_CNT)) ? S_SLEEPING : S_WORKING;
                  end else begin
                     zero_d  = '0;
                     state_d = S_WORKING;
                  end
               end
            end
            S_CLEARING: begin
               // cnt parks at DATA_DEPTH once the sweep is done but clear_req is still held
               if ((cnt_q >= CNT_W'(DATA_DEPTH - 1)) && !bus.clear_req) begin
                  state_d = S_WAIT_IN;
                  cnt_d   = '0;
                  x_ptr_d = ADDR_X'(DATA_DEPTH - 1);
                  zero_d  = '0;
                  busy_d  = 1'b0;
               end else if (cnt_q < CNT_W'(DATA_DEPTH)) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = S_INIT;
         endcase
      end
      in_ready_d = (state_d != S_INIT) && (state_d != S_CLEARING);
   end

   always_comb begin
      rj_we        = 1'b0;
      coef_we      = 1'b0;
      data_we      = 1'b0;
      data_wr_zero = 1'b0;
      wr_addr      = '0;
      take_data    = 1'b0;
      // outputs are held at 0 while reset is asserted and on a Start cycle
      if (Reset_n && !bus.Start) begin
         case (state_q)
            S_INIT: begin
               data_we      = 1'b1;
               data_wr_zero = 1'b1;
               wr_addr      = 9'(cnt_q);
            end
            S_READ_RJ: begin
               rj_we   = bus.word_valid;
               wr_addr = bus.word_valid ? 9'(cnt_q) : 9'd0;
            end
            S_READ_COEF: begin
               coef_we = bus.word_valid;
               wr_addr = bus.word_valid ? 9'(cnt_q) : 9'd0;
            end
            S_WAIT_IN, S_WORKING: take_data = bus.word_valid && !bus.clear_req;
            S_SLEEPING: take_data = bus.word_valid && !bus.word_zero && !bus.clear_req;
            S_CLEARING: begin
               if (cnt_q < CNT_W'(DATA_DEPTH)) begin
                  data_we      = 1'b1;
                  data_wr_zero = 1'b1;
                  wr_addr      = 9'(cnt_q);
               end
            end
            default: ;
         endcase
         if (take_data) begin
            data_we = 1'b1;
            wr_addr = 9'(x_ptr_inc);
         end
      end
   end

   assign bus.rj_we        = rj_we;
   assign bus.coef_we      = coef_we;
   assign bus.data_we      = data_we;
   assign bus.data_wr_zero = data_wr_zero;
   assign bus.wr_addr      = wr_addr;
   assign bus.InReady      = in_ready_q;
   assign bus.x_ptr        = x_ptr_q;
   assign bus.comp_start   = comp_start_q;
   assign bus.sleep        = (state_q == S_SLEEPING);
   assign bus.overrun      = overrun_q;
   assign bus.state        = state_q;
endmodule
